// File: rtl/fp_convert_writeback_pkg.sv
// Shared types for the FP converter writeback stage.
//   word_t / uint64_t / fflags_t : result and exception-flag types
//   FpWritebackEntry             : one buffered converter result
package fp_convert_writeback_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] uint64_t;
  typedef logic [4:0]  fflags_t;

  // Flag bit order: {NV, DZ, OF, UF, NX}
  localparam fflags_t FFLAGS_NONE = 5'b00000;

  typedef struct packed {
    logic       isIntDest;
    logic [4:0] rd;
    uint64_t    value;
    fflags_t    flags;
  } FpWritebackEntry;

  // Integer results are zero-extended into the shared 64-bit value slot.
  function automatic FpWritebackEntry make_entry(
    input logic       is_int,
    input logic [4:0] rd,
    input word_t      int_res,
    input uint64_t    fp_res,
    input fflags_t    flags
  );
    FpWritebackEntry e;
    e.isIntDest = is_int;
    e.rd        = rd;
    e.value     = is_int ? {32'b0, int_res} : fp_res;
    e.flags     = flags;
    return e;
  endfunction

endpackage

// File: rtl/fp_writeback_fifo.sv
// Generic DEPTH-entry valid/ready FIFO with synchronous flush.
//   i_valid/o_ready/i_data : enqueue side (accept when i_valid && o_ready)
//   o_valid/o_data/i_pop   : head side (pop when i_pop && o_valid)
//   flush                  : empties the FIFO at the edge, drops a same-cycle push
// o_ready depends only on registered count, never on i_pop.
module fp_writeback_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  output T     o_data,
  input  logic i_pop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push, w_pop;

  assign o_ready = (r_count < CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push  = i_valid && o_ready && !flush;
  assign w_pop   = i_pop && o_valid && !flush;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: contents are only observed through o_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fp_convert_writeback.sv
// Writeback stage after the FP converter.
//   inValid/inReady + result fields : converter result intake (buffered in a FIFO)
//   wbGrant                         : arbiter grant for the head's write port
//   int*/fp* write ports            : register-file writes driven from the FIFO head
//   csrFlagsWrite/csrFlagsValue     : CSR write of fflags
//   fflags                          : accumulated exception flags of retired results
//   flush                           : discards buffered and incoming results
//   busy                            : FIFO non-empty
module fp_convert_writeback
  import fp_convert_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  word_t       inIntResult,
  input  uint64_t     inFpResult,
  input  fflags_t     inFlags,
  input  logic [4:0]  inRd,
  input  logic        inIsIntDest,
  input  logic        flush,
  input  logic        wbGrant,
  output logic        intWriteEnable,
  output logic [4:0]  intWriteAddr,
  output word_t       intWriteValue,
  output logic        fpWriteEnable,
  output logic [4:0]  fpWriteAddr,
  output uint64_t     fpWriteValue,
  input  logic        csrFlagsWrite,
  input  fflags_t     csrFlagsValue,
  output fflags_t     fflags,
  output logic        busy
);

  FpWritebackEntry w_in_entry, w_head;
  logic            w_head_valid;
  logic            w_x0_write;
  logic            w_retire;
  fflags_t         w_retire_flags;
  fflags_t         r_fflags;

  assign w_in_entry = make_entry(inIsIntDest, inRd, inIntResult, inFpResult, inFlags);

  fp_writeback_fifo #(
    .DEPTH (DEPTH),
    .T     (FpWritebackEntry)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (inValid),
    .o_ready (inReady),
    .i_data  (w_in_entry),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .i_pop   (w_retire)
  );

  // Writes to x0 are architecturally discarded, so they retire without a grant.
  assign w_x0_write     = w_head.isIntDest && (w_head.rd == 5'd0);
  assign w_retire       = w_head_valid && !flush && (wbGrant || w_x0_write);
  assign w_retire_flags = w_retire ? w_head.flags : FFLAGS_NONE;

  assign intWriteEnable = w_head_valid && w_head.isIntDest && (w_head.rd != 5'd0) && !flush;
  assign fpWriteEnable  = w_head_valid && !w_head.isIntDest && !flush;
  assign intWriteAddr   = w_head_valid ? w_head.rd : 5'd0;
  assign intWriteValue  = w_head_valid ? w_head.value[31:0] : '0;
  assign fpWriteAddr    = w_head_valid ? w_head.rd : 5'd0;
  assign fpWriteValue   = w_head_valid ? w_head.value : '0;
  assign busy           = w_head_valid;

  // A retiring result is older than a same-cycle CSR write, yet its flags
  // still land on top of the CSR value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_fflags <= FFLAGS_NONE;
    else if (csrFlagsWrite) r_fflags <= csrFlagsValue | w_retire_flags;
    else                    r_fflags <= r_fflags | w_retire_flags;
  end

  assign fflags = r_fflags;

endmodule

// File: tb/tb_fp_convert_writeback.sv
module tb_fp_convert_writeback;
  import fp_convert_writeback_pkg::*;

  localparam int DEPTH = 2;

  logic        clk, rst;
  logic        inValid, inReady;
  word_t       inIntResult;
  uint64_t     inFpResult;
  fflags_t     inFlags;
  logic [4:0]  inRd;
  logic        inIsIntDest, flush, wbGrant;
  logic        intWriteEnable, fpWriteEnable;
  logic [4:0]  intWriteAddr, fpWriteAddr;
  word_t       intWriteValue;
  uint64_t     fpWriteValue;
  logic        csrFlagsWrite;
  fflags_t     csrFlagsValue, fflags;
  logic        busy;

  fp_convert_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inIntResult(inIntResult), .inFpResult(inFpResult), .inFlags(inFlags),
    .inRd(inRd), .inIsIntDest(inIsIntDest), .flush(flush), .wbGrant(wbGrant),
    .intWriteEnable(intWriteEnable), .intWriteAddr(intWriteAddr),
    .intWriteValue(intWriteValue), .fpWriteEnable(fpWriteEnable),
    .fpWriteAddr(fpWriteAddr), .fpWriteValue(fpWriteValue),
    .csrFlagsWrite(csrFlagsWrite), .csrFlagsValue(csrFlagsValue),
    .fflags(fflags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v, isint, fl, gr, csrw;
    logic [4:0]  rd, flags, csrv;
    logic [31:0] ir;
    logic [63:0] fr;
    bit          er, eb, eiwe, efwe;
    logic [4:0]  eaddr, eff;
    logic [63:0] eval;
  } vec_t;

  function automatic vec_t mk(
    input bit v, input bit isint, input logic [4:0] rd, input logic [31:0] ir,
    input logic [63:0] fr, input logic [4:0] flags, input bit fl, input bit gr,
    input bit csrw, input logic [4:0] csrv, input bit er, input bit eb,
    input bit eiwe, input bit efwe, input logic [4:0] eaddr, input logic [63:0] eval,
    input logic [4:0] eff);
    vec_t t;
    t.v = v; t.isint = isint; t.rd = rd; t.ir = ir; t.fr = fr; t.flags = flags;
    t.fl = fl; t.gr = gr; t.csrw = csrw; t.csrv = csrv; t.er = er; t.eb = eb;
    t.eiwe = eiwe; t.efwe = efwe; t.eaddr = eaddr; t.eval = eval; t.eff = eff;
    return t;
  endfunction

  vec_t vecs[17];

  task automatic drive_idle();
    inValid = 0; inIntResult = '0; inFpResult = '0; inFlags = '0; inRd = '0;
    inIsIntDest = 0; flush = 0; wbGrant = 0; csrFlagsWrite = 0; csrFlagsValue = '0;
  endtask

  task automatic apply_vec(input vec_t t, input int idx);
    string s;
    inValid = t.v; inIsIntDest = t.isint; inRd = t.rd; inIntResult = t.ir;
    inFpResult = t.fr; inFlags = t.flags; flush = t.fl; wbGrant = t.gr;
    csrFlagsWrite = t.csrw; csrFlagsValue = t.csrv;
    @(negedge clk);
    s = $sformatf("vec%0d", idx);
    chk({s, ".inReady"}, 64'(inReady), 64'(t.er));
    chk({s, ".busy"}, 64'(busy), 64'(t.eb));
    chk({s, ".intWE"}, 64'(intWriteEnable), 64'(t.eiwe));
    chk({s, ".fpWE"}, 64'(fpWriteEnable), 64'(t.efwe));
    chk({s, ".fflags"}, 64'(fflags), 64'(t.eff));
    if (t.eiwe) begin
      chk({s, ".intAddr"}, 64'(intWriteAddr), 64'(t.eaddr));
      chk({s, ".intVal"}, 64'(intWriteValue), 64'(t.eval[31:0]));
    end
    if (t.efwe) begin
      chk({s, ".fpAddr"}, 64'(fpWriteAddr), 64'(t.eaddr));
      chk({s, ".fpVal"}, fpWriteValue, t.eval);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          isint;
    logic [4:0]  rd;
    logic [63:0] val;
    logic [4:0]  flags;
  } ment_t;

  ment_t       q[$];
  logic [4:0]  m_fflags;

  task automatic model_check();
    bit hv, eiwe, efwe;
    ment_t h;
    hv = (q.size() != 0);
    h = '{0, 5'd0, 64'd0, 5'd0};
    if (hv) h = q[0];
    eiwe = hv && h.isint && h.rd != 0 && !flush;
    efwe = hv && !h.isint && !flush;
    chk("rnd.inReady", 64'(inReady), 64'(q.size() < DEPTH));
    chk("rnd.busy", 64'(busy), 64'(hv));
    chk("rnd.intWE", 64'(intWriteEnable), 64'(eiwe));
    chk("rnd.fpWE", 64'(fpWriteEnable), 64'(efwe));
    chk("rnd.fflags", 64'(fflags), 64'(m_fflags));
    chk("rnd.intAddr", 64'(intWriteAddr), 64'(h.rd));
    chk("rnd.intVal", 64'(intWriteValue), 64'(h.val[31:0]));
    chk("rnd.fpAddr", 64'(fpWriteAddr), 64'(h.rd));
    chk("rnd.fpVal", fpWriteValue, h.val);
  endtask

  task automatic model_update();
    bit ready, retire;
    logic [4:0] rf;
    ment_t e;
    ready = q.size() < DEPTH;
    if (flush) begin
      q.delete();
      if (csrFlagsWrite) m_fflags = csrFlagsValue;
      return;
    end
    retire = q.size() != 0 && (wbGrant || (q[0].isint && q[0].rd == 0));
    rf = retire ? q[0].flags : 5'd0;
    m_fflags = csrFlagsWrite ? (csrFlagsValue | rf) : (m_fflags | rf);
    if (retire) void'(q.pop_front());
    if (inValid && ready) begin
      e.isint = inIsIntDest; e.rd = inRd; e.flags = inFlags;
      e.val = inIsIntDest ? {32'b0, inIntResult} : inFpResult;
      q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".inReady"}, 64'(inReady), 64'd1);
    chk({nm, ".busy"}, 64'(busy), 64'd0);
    chk({nm, ".fflags"}, 64'(fflags), 64'd0);
    chk({nm, ".intWE"}, 64'(intWriteEnable), 64'd0);
    chk({nm, ".fpWE"}, 64'(fpWriteEnable), 64'd0);
    chk({nm, ".intAddr"}, 64'(intWriteAddr), 64'd0);
    chk({nm, ".intVal"}, 64'(intWriteValue), 64'd0);
    chk({nm, ".fpAddr"}, 64'(fpWriteAddr), 64'd0);
    chk({nm, ".fpVal"}, fpWriteValue, 64'd0);
  endtask

  initial begin
    //          v isint rd  ir          fr                     flags   fl gr cw csrv     er eb iwe fwe addr val                    eff
    vecs[0]  = mk(1, 1, 5, 32'h7fff_ffff, 64'd0, 5'b10000, 0, 1, 0, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b00000);
    vecs[1]  = mk(0, 0, 0, 32'd0, 64'd0, 5'b0, 0, 1, 0, 5'b0, 1, 1, 1, 0, 5'd5, 64'h7fff_ffff, 5'b00000);
    vecs[2]  = mk(0, 0, 0, 32'd0, 64'd0, 5'b0, 0, 0, 0, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b10000);
    vecs[3]  = mk(1, 1, 0, 32'd9, 64'd0, 5'b00001, 0, 0, 1, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b10000);
    vecs[4]  = mk(0, 0, 0, 32'd0, 64'd0, 5'b0, 0, 0, 0, 5'b0, 1, 1, 0, 0, 5'd0, 64'd0, 5'b00000);
    vecs[5]  = mk(1, 0, 7, 32'd0, 64'h4000_0000_0000_0001, 5'b00001, 0, 0, 0, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b00001);
    vecs[6]  = mk(0, 0, 0, 32'd0, 64'd0, 5'b0, 0, 1, 1, 5'b00100, 1, 1, 0, 1, 5'd7, 64'h4000_0000_0000_0001, 5'b00001);
    vecs[7]  = mk(1, 1, 1, 32'h11, 64'd0, 5'b0, 0, 0, 0, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b00101);
    vecs[8]  = mk(1, 1, 2, 32'h22, 64'd0, 5'b0, 0, 0, 0, 5'b0, 1, 1, 1, 0, 5'd1, 64'h11, 5'b00101);
    vecs[9]  = mk(1, 1, 3, 32'h33, 64'd0, 5'b0, 0, 0, 0, 5'b0, 0, 1, 1, 0, 5'd1, 64'h11, 5'b00101);
    vecs[10] = mk(1, 1, 3, 32'h33, 64'd0, 5'b0, 0, 1, 0, 5'b0, 0, 1, 1, 0, 5'd1, 64'h11, 5'b00101);
    vecs[11] = mk(1, 1, 3, 32'h33, 64'd0, 5'b0, 0, 1, 0, 5'b0, 1, 1, 1, 0, 5'd2, 64'h22, 5'b00101);
    vecs[12] = mk(0, 0, 0, 32'd0, 64'd0, 5'b0, 0, 1, 0, 5'b0, 1, 1, 1, 0, 5'd3, 64'h33, 5'b00101);
    vecs[13] = mk(1, 1, 4, 32'h44, 64'd0, 5'b01000, 0, 0, 0, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b00101);
    vecs[14] = mk(1, 1, 5, 32'h55, 64'd0, 5'b00100, 0, 0, 0, 5'b0, 1, 1, 1, 0, 5'd4, 64'h44, 5'b00101);
    vecs[15] = mk(1, 1, 6, 32'h66, 64'd0, 5'b00010, 1, 1, 0, 5'b0, 0, 1, 0, 0, 5'd0, 64'd0, 5'b00101);
    vecs[16] = mk(0, 0, 0, 32'd0, 64'd0, 5'b0, 0, 0, 0, 5'b0, 1, 0, 0, 0, 5'd0, 64'd0, 5'b00101);

    drive_idle();
    rst = 1;
    #12 check_all_zero("reset");
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

    // Fill the FIFO with fflags = 11111, then assert reset between edges.
    drive_idle();
    csrFlagsWrite = 1; csrFlagsValue = 5'b11111;
    inValid = 1; inIsIntDest = 1; inRd = 5'd9; inIntResult = 32'h99;
    @(posedge clk); #1;
    csrFlagsWrite = 0; inRd = 5'd10; inIntResult = 32'hAA;
    @(posedge clk); #1;
    inValid = 0;
    #2;
    chk("full.inReady", 64'(inReady), 64'd0);
    chk("full.busy", 64'(busy), 64'd1);
    chk("full.fflags", 64'(fflags), 64'h1f);
    rst = 1;
    #1 check_all_zero("asyncrst");
    @(posedge clk); #1 rst = 0;

    // Randomized phase against the reference model.
    q.delete();
    m_fflags = 5'd0;
    for (int n = 0; n < 400; n++) begin
      inValid       = ($urandom_range(0, 3) != 0);
      inIsIntDest   = $urandom_range(0, 1) == 1;
      inRd          = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      inIntResult   = $urandom;
      inFpResult    = {$urandom, $urandom};
      inFlags       = 5'($urandom_range(0, 31));
      flush         = ($urandom_range(0, 19) == 0);
      wbGrant       = $urandom_range(0, 1) == 1;
      csrFlagsWrite = ($urandom_range(0, 15) == 0);
      csrFlagsValue = 5'($urandom_range(0, 31));
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_convert_writeback.md
# fp_convert_writeback

Writeback stage directly downstream of the FP converter. Accepts each converter result (integer or FP destination plus exception flags), buffers it in a small FIFO, drives the integer or FP register-file write port when granted, and accumulates the flags of retired results into the architectural `fflags` register. It decouples the single-cycle converter from write-port arbitration and owns CSR-visible `fflags` for converter operations.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, at least 2.
- `clk`  input  1  clock
- `rst`  input  1  reset; asynchronous, active-high
- `inValid`  input  1  converter result valid
- `inReady`  output  1  entry free; the result is accepted when `inValid && inReady`
- `inIntResult`  input  32  integer result (`word_t`)
- `inFpResult`  input  64  FP result (`uint64_t`)
- `inFlags`  input  5  `fflags_t` from the converter
- `inRd`  input  5  destination register index
- `inIsIntDest`  input  1  1 = integer register file, 0 = FP register file
- `flush`  input  1  pipeline kill; discards all buffered and incoming results
- `wbGrant`  input  1  the arbiter grants the head's write port this cycle
- `intWriteEnable`  output  1  integer register file write
- `intWriteAddr`  output  5
- `intWriteValue`  output  32
- `fpWriteEnable`  output  1  FP register file write
- `fpWriteAddr`  output  5
- `fpWriteValue`  output  64
- `csrFlagsWrite`  input  1  CSR instruction writes `fflags`
- `csrFlagsValue`  input  5  value written
- `fflags`  output  5  accumulated flags (registered)
- `busy`  output  1  FIFO non-empty

## Operation
- Each entry holds `{isIntDest, rd, value[63:0], flags}`. For integer destinations, `value` = `{32'b0, inIntResult}`; otherwise `value` = `inFpResult`.
- Head drive (combinational from registers):
  - `intWriteEnable` = `headValid && isIntDest && rd != 0 && !flush`.
  - `fpWriteEnable` = `headValid && !isIntDest && !flush`.
  - Address and value come from the head. When the FIFO is empty, they are 0.
- Retire: the head leaves the FIFO when `headValid && !flush`, and either `wbGrant` is high or the head is an integer destination with `rd == 0`. An x0 write retires without a grant and with no write enable asserted.
- Flag accumulation on retire: `fflags <= fflags | head.flags`.
- CSR write in the same cycle as a retire: `fflags <= csrFlagsValue | head.flags`. The retiring instruction is older, but its flags are still architecturally ORed in.
- CSR write with no retire: `fflags <= csrFlagsValue`.
- `flush`: at the edge, count and pointers go to 0. A same-cycle input is dropped. No retire occurs and no flags accumulate. A CSR write in a flush cycle still takes effect.
- Pointers wrap modulo `DEPTH`. Count width is `$clog2(DEPTH)+1`.

## Timing
- Reset values:
  - count, pointers = 0.
  - `fflags` = 0.
  - All write enables = 0. Addresses and values = 0.
  - `inReady` = 1. `busy` = 0.
- Latency: a result accepted at edge N is at the head and drives the write port in cycle N+1 (if the FIFO was empty). It retires at the first following edge with `wbGrant`. Its flags are visible on `fflags` the cycle after retire.
- `inReady` = `count < DEPTH`. It is registered-state only and does not depend on `wbGrant` in the same cycle. A full FIFO therefore stalls for one cycle even if the head retires.
- Simultaneous accept and retire: count unchanged, both pointers advance.
- Reset asserted mid-operation: all state clears asynchronously, and pending results and flags are lost.

## Structure
- `FpWritebackEntry` struct goes in `OpTypes`. `fflags_t`, `word_t` and `uint64_t` are already shared.
- One sub-module, `fp_writeback_fifo`: a generic DEPTH-entry valid/ready FIFO with `flush`, parameterized by the entry type. Flag and CSR logic stays in the top module.

## Test plan
- Integer result `32'h7fff_ffff`, rd=5, flags NV, `wbGrant` held high, `fflags`=0 -> `intWriteEnable` with addr 5 and value `7fff_ffff` one cycle after accept; `fflags`=`5'b10000` the following cycle.
- Three back-to-back inputs with `wbGrant`=0 and DEPTH=2 -> first two accepted, `inReady`=0, third held. Raise grant -> retire in order, then third accepted.
- Integer entry with rd=0 and flags NX, `wbGrant`=0 -> retires in one cycle, no write enable, `fflags`=`5'b00001`.
- Head retiring with flags NX while `csrFlagsWrite` with value `5'b00100` -> `fflags`=`5'b00101`.
- Two buffered entries, `flush` in the same cycle as a new input and `wbGrant` -> no writes, `busy`=0 and `fflags` unchanged next cycle.
- Reset asserted while full, with `fflags`=`5'b11111` -> all outputs zero, `inReady`=1 immediately, without waiting for a clock edge.
